// File: rtl/rsa_pkg.sv
// Shared constants, sequencer state encoding and operand payload for the MonPro sequencer.
package rsa_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned NUM_WORDS  = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      FETCH,
      DRAIN,
      ERR
   } state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] m;
      logic [DATA_WIDTH-1:0] e;
      logic [DATA_WIDTH-1:0] n;
   } operand_t;

endpackage

// File: rtl/monpro_seq_ctrl_if.sv
// Host operand/result handshakes plus the MonPro core strobes, bundled for the sequencer.
interface monpro_seq_ctrl_if;
   import rsa_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_m;
   logic [DATA_WIDTH-1:0] in_e;
   logic [DATA_WIDTH-1:0] in_n;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   logic                  busy;
   logic                  error;
   logic                  err_clr;

   logic                  core_start;
   logic [DATA_WIDTH-1:0] core_m;
   logic [DATA_WIDTH-1:0] core_e;
   logic [DATA_WIDTH-1:0] core_n;
   logic                  core_get_result;
   logic                  core_done;
   logic [DATA_WIDTH-1:0] core_res;

   // Controller side
   modport master (
      input  in_valid, in_m, in_e, in_n, out_ready, err_clr, core_done, core_res,
      output in_ready, out_valid, out_data, busy, error,
             core_start, core_m, core_e, core_n, core_get_result
   );

   // Host plus MonPro core side
   modport slave (
      output in_valid, in_m, in_e, in_n, out_ready, err_clr, core_done, core_res,
      input  in_ready, out_valid, out_data, busy, error,
             core_start, core_m, core_e, core_n, core_get_result
   );

endinterface

// File: rtl/res_word_buf.sv
// Result word buffer: synchronous write from the core, combinational read toward the host.
module res_word_buf
   import rsa_pkg::*;
(
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/monpro_seq_ctrl.sv
// Sequencer for the MonPro datapath: streams operands in, waits under a watchdog,
// pulls the result into a local buffer and streams it back to the host.
module monpro_seq_ctrl
   import rsa_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned TO_W           = 21
) (
   input logic               clk,
   input logic               reset,
   monpro_seq_ctrl_if.master ctrl_if
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
   localparam logic [TO_W-1:0]  WDOG_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e                state_q;
   logic [CNT_W-1:0]      wcnt_q;
   logic [CNT_W-1:0]      rcnt_q;
   logic [CNT_W-1:0]      rptr_q;
   logic [TO_W-1:0]       wdog_q;
   operand_t              operand_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic                  error_q;
   logic                  core_start_q;
   logic                  core_get_q;
   logic                  res_vld_q;

   logic                  accept;
   logic                  buf_we;
   logic [DATA_WIDTH-1:0] buf_rdata;

   assign accept = ctrl_if.in_valid & in_ready_q;
   // core_res trails each getResult cycle by one, hence the delayed valid
   assign buf_we = (state_q == FETCH) & res_vld_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         rptr_q       <= '0;
         wdog_q       <= '0;
         operand_q    <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
         core_start_q <= 1'b0;
         core_get_q   <= 1'b0;
         res_vld_q    <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         res_vld_q    <= core_get_q;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  operand_q    <= '{m: ctrl_if.in_m, e: ctrl_if.in_e, n: ctrl_if.in_n};
                  core_start_q <= 1'b1;
                  wcnt_q       <= CNT_W'(1);
                  busy_q       <= 1'b1;
                  state_q      <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  operand_q    <= '{m: ctrl_if.in_m, e: ctrl_if.in_e, n: ctrl_if.in_n};
                  core_start_q <= 1'b1;
                  wcnt_q       <= wcnt_q + CNT_W'(1);
                  if (wcnt_q == LAST_WORD) begin
                     wdog_q     <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= WAIT;
                  end
               end
            end
            WAIT: begin
               // core_done wins over a coincident timeout
               if (ctrl_if.core_done) begin
                  wcnt_q     <= '0;
                  rcnt_q     <= '0;
                  core_get_q <= 1'b1;
                  state_q    <= FETCH;
               end else if (wdog_q == WDOG_LAST) begin
                  error_q <= 1'b1;
                  state_q <= ERR;
               end else if (wdog_q != '1) begin
                  wdog_q <= wdog_q + TO_W'(1);
               end
            end
            FETCH: begin
               if (core_get_q) begin
                  wcnt_q <= wcnt_q + CNT_W'(1);
                  if (wcnt_q == LAST_WORD) begin
                     core_get_q <= 1'b0;
                  end
               end
               if (res_vld_q) begin
                  rcnt_q <= rcnt_q + CNT_W'(1);
                  if (rcnt_q == LAST_WORD) begin
                     rptr_q      <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (ctrl_if.out_ready) begin
                  rptr_q <= rptr_q + CNT_W'(1);
                  if (rptr_q == LAST_WORD) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
            end
            ERR: begin
               if (ctrl_if.err_clr) begin
                  error_q    <= 1'b0;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   res_word_buf u_res_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (rcnt_q[ADDR_WIDTH-1:0]),
      .wdata_i (ctrl_if.core_res),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (buf_rdata)
   );

   assign ctrl_if.in_ready        = in_ready_q;
   assign ctrl_if.out_valid       = out_valid_q;
   assign ctrl_if.out_data        = out_valid_q ? buf_rdata : '0;
   assign ctrl_if.busy            = busy_q;
   assign ctrl_if.error           = error_q;
   assign ctrl_if.core_start      = core_start_q;
   assign ctrl_if.core_m          = operand_q.m;
   assign ctrl_if.core_e          = operand_q.e;
   assign ctrl_if.core_n          = operand_q.n;
   assign ctrl_if.core_get_result = core_get_q;

endmodule

// File: tb/tb_monpro_seq_ctrl.sv
// Directed bench for monpro_seq_ctrl: a long-timeout instance for data-path transactions
// and a 64-cycle-timeout instance for the watchdog and error-clear path.
module tb_monpro_seq_ctrl;
   import rsa_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   monpro_seq_ctrl_if ifc ();
   monpro_seq_ctrl_if ifw ();

   monpro_seq_ctrl #(.TIMEOUT_CYCLES(1048576), .TO_W(21)) dut (
      .clk     (clk),
      .reset   (reset),
      .ctrl_if (ifc.master)
   );

   monpro_seq_ctrl #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut_wd (
      .clk     (clk),
      .reset   (reset),
      .ctrl_if (ifw.master)
   );

   int checks = 0;
   int errors = 0;

   // Start-strobe and getResult monitor for the main instance
   logic [95:0] st_q[$];
   int          st_cyc[$];
   int          cyc = 0;
   bit          acc_prev = 1'b0;
   int          start_orphan = 0;
   int          start_miss = 0;
   int          get_run = 0;
   int          last_run = 0;

   always @(posedge clk) begin
      if (ifc.core_start) begin
         st_q.push_back({ifc.core_m, ifc.core_e, ifc.core_n});
         st_cyc.push_back(cyc);
         if (!acc_prev) start_orphan++;
      end else if (acc_prev) begin
         start_miss++;
      end
      acc_prev = ifc.in_valid && ifc.in_ready && !reset;
      if (ifc.core_get_result) get_run++;
      else if (get_run != 0) begin
         last_run = get_run;
         get_run  = 0;
      end
      cyc++;
   end

   // MonPro result models: word i of a fetch returns A0000000+i one cycle later
   int gidx = 0;
   int gidx_w = 0;

   always @(posedge clk) begin
      if (ifc.core_done) gidx = 0;
      if (ifc.core_get_result) begin
         #1 ifc.core_res = 32'hA000_0000 + 32'(gidx);
         gidx++;
      end
   end

   always @(posedge clk) begin
      if (ifw.core_done) gidx_w = 0;
      if (ifw.core_get_result) begin
         #1 ifw.core_res = 32'hA000_0000 + 32'(gidx_w);
         gidx_w++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] word_of(input int i, input bit pat);
      if (i == 0) return {32'h0000_0005, 32'h0001_0001, 32'h8B94_96E5};
      if (pat)    return {32'(i + 1), 32'(i * 3), 32'hF000_0000 | 32'(i)};
      return '0;
   endfunction

   task automatic send(input bit pat, input int gap_after, input int gap_len, input int done_at);
      logic [95:0] w;
      for (int i = 0; i < NUM_WORDS; i++) begin
         w = word_of(i, pat);
         ifc.in_valid  = 1'b1;
         {ifc.in_m, ifc.in_e, ifc.in_n} = w;
         ifc.core_done = (i == done_at);
         tick();
         ifc.core_done = 1'b0;
         if (i == gap_after) begin
            ifc.in_valid = 1'b0;
            repeat (gap_len) tick();
         end
      end
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain(input bit stall, output int got);
      bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          budget = 0;
      int          ph = 0;
      bit          stalled = 1'b0;
      logic [31:0] held = '0;
      got = 0;
      while (!ifc.out_valid && budget < 200) begin
         tick();
         budget++;
      end
      while (got < NUM_WORDS && budget < 1000) begin
         ifc.out_ready = stall ? pat[ph % 4] : 1'b1;
         ph++;
         if (stalled) chk("drain_hold_stable", ifc.out_data, held);
         if (ifc.out_valid && ifc.out_ready) begin
            chk("drain_word", ifc.out_data, 32'hA000_0000 + 32'(got));
            got++;
            stalled = 1'b0;
         end else begin
            held    = ifc.out_data;
            stalled = ifc.out_valid;
         end
         tick();
         budget++;
      end
      ifc.out_ready = 1'b0;
   endtask

   task automatic finish_txn(input int lat, input bit stall, input string tag);
      int got;
      chk({tag, "_wait_in_ready"}, 32'(ifc.in_ready), 32'd0);
      chk({tag, "_wait_busy"}, 32'(ifc.busy), 32'd1);
      repeat (lat - 1) tick();
      ifc.core_done = 1'b1;
      tick();
      ifc.core_done = 1'b0;
      drain(stall, got);
      chk({tag, "_words_delivered"}, 32'(got), 32'(NUM_WORDS));
      chk({tag, "_busy_after"}, 32'(ifc.busy), 32'd0);
      chk({tag, "_out_valid_after"}, 32'(ifc.out_valid), 32'd0);
      chk({tag, "_get_result_run"}, 32'(last_run), 32'(NUM_WORDS));
   endtask

   int base;
   int bad;
   int early;
   int got;
   int budget;

   initial begin
      {ifc.in_valid, ifc.out_ready, ifc.err_clr, ifc.core_done} = '0;
      {ifc.in_m, ifc.in_e, ifc.in_n, ifc.core_res} = '0;
      {ifw.in_valid, ifw.out_ready, ifw.err_clr, ifw.core_done} = '0;
      {ifw.in_m, ifw.in_e, ifw.in_n, ifw.core_res} = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_data", ifc.out_data, 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_error", 32'(ifc.error), 32'd0);
      chk("rst_core_start", 32'(ifc.core_start), 32'd0);
      chk("rst_core_get", 32'(ifc.core_get_result), 32'd0);
      chk("rst_core_mxn", ifc.core_m | ifc.core_e | ifc.core_n, 32'd0);

      // Contiguous transaction, 500-cycle core latency
      base = st_q.size();
      send(1'b0, -1, 0, -1);
      tick();
      chk("t1_start_count", 32'(st_q.size() - base), 32'(NUM_WORDS));
      chk("t1_word0", st_q[base][31:0], 32'h8B94_96E5);
      chk("t1_word0_m", st_q[base][95:64], 32'h0000_0005);
      finish_txn(500, 1'b0, "t1");

      // Three-cycle input gap after word 10, distinguishable words
      base = st_q.size();
      send(1'b1, 10, 3, -1);
      tick();
      chk("t2_start_count", 32'(st_q.size() - base), 32'(NUM_WORDS));
      chk("t2_gap_spacing", 32'(st_cyc[base + 11] - st_cyc[base + 10]), 32'd4);
      chk("t2_no_gap_before", 32'(st_cyc[base + 10] - st_cyc[base + 9]), 32'd1);
      bad = 0;
      for (int i = 0; i < NUM_WORDS; i++) if (st_q[base + i] !== word_of(i, 1'b1)) bad++;
      chk("t2_word_order", 32'(bad), 32'd0);
      finish_txn(500, 1'b0, "t2");

      // Backpressure during DRAIN
      send(1'b0, -1, 0, -1);
      tick();
      finish_txn(40, 1'b1, "t3");

      // Reset on FETCH cycle 5
      send(1'b0, -1, 0, -1);
      tick();
      repeat (19) tick();
      ifc.core_done = 1'b1;
      tick();
      ifc.core_done = 1'b0;
      repeat (5) tick();
      chk("t5_fetch_active", 32'(ifc.core_get_result), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_get_cleared", 32'(ifc.core_get_result), 32'd0);
      chk("t5_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("t5_busy", 32'(ifc.busy), 32'd0);
      chk("t5_in_ready", 32'(ifc.in_ready), 32'd1);
      send(1'b0, -1, 0, -1);
      tick();
      finish_txn(30, 1'b0, "t5_retry");

      // core_done outside WAIT is ignored
      ifc.core_done = 1'b1;
      tick();
      ifc.core_done = 1'b0;
      chk("t6_idle_busy", 32'(ifc.busy), 32'd0);
      chk("t6_idle_in_ready", 32'(ifc.in_ready), 32'd1);
      send(1'b0, -1, 0, 7);
      repeat (20) tick();
      chk("t6_still_wait_get", 32'(ifc.core_get_result), 32'd0);
      chk("t6_still_wait_valid", 32'(ifc.out_valid), 32'd0);
      finish_txn(10, 1'b0, "t6");

      chk("start_orphans", 32'(start_orphan), 32'd0);
      chk("start_missed", 32'(start_miss), 32'd0);

      // Watchdog: error rises exactly 64 cycles after entering WAIT
      ifw.in_valid = 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) begin
         ifw.in_m = 32'(i);
         tick();
      end
      early = 0;
      for (int k = 1; k < 64; k++) begin
         tick();
         if (ifw.error !== 1'b0) early++;
      end
      chk("wd_no_early_error", 32'(early), 32'd0);
      tick();
      chk("wd_error_at_64", 32'(ifw.error), 32'd1);
      chk("wd_in_ready_low", 32'(ifw.in_ready), 32'd0);
      chk("wd_busy", 32'(ifw.busy), 32'd1);
      repeat (5) tick();
      chk("wd_error_sticky", 32'(ifw.error), 32'd1);
      chk("wd_in_ready_held", 32'(ifw.in_ready), 32'd0);
      chk("wd_no_strobes", 32'(ifw.core_start | ifw.core_get_result), 32'd0);
      ifw.in_valid = 1'b0;
      ifw.err_clr  = 1'b1;
      tick();
      ifw.err_clr  = 1'b0;
      chk("wd_clr_error", 32'(ifw.error), 32'd0);
      chk("wd_clr_in_ready", 32'(ifw.in_ready), 32'd1);
      chk("wd_clr_busy", 32'(ifw.busy), 32'd0);

      // Fresh transaction after clearing the error
      ifw.in_valid = 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) tick();
      ifw.in_valid = 1'b0;
      repeat (9) tick();
      ifw.core_done = 1'b1;
      tick();
      ifw.core_done = 1'b0;
      ifw.out_ready = 1'b1;
      got = 0;
      bad = 0;
      budget = 0;
      while (got < NUM_WORDS && budget < 300) begin
         if (ifw.out_valid) begin
            if (ifw.out_data !== 32'hA000_0000 + 32'(got)) bad++;
            got++;
         end
         tick();
         budget++;
      end
      ifw.out_ready = 1'b0;
      chk("wd_retry_words", 32'(got), 32'(NUM_WORDS));
      chk("wd_retry_data", 32'(bad), 32'd0);
      chk("wd_retry_busy", 32'(ifw.busy), 32'd0);
      chk("wd_retry_error", 32'(ifw.error), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
